// File: rtl/fofb_reset_sequencer.sv
// Multi-channel reset / link-up sequencer: global hold, staggered per-channel release,
// per-channel timeout with bounded retry. Optional RSTSEQ_RELINK_EN re-links dropped channels in DONE.
module fofb_reset_sequencer #(
  parameter int unsigned NUM_CHAN       = 4,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned HOLD_CYCLES    = 50,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [NUM_CHAN-1:0] chan_en_i,
  input  logic [NUM_CHAN-1:0] done_i,
  output logic [NUM_CHAN-1:0] chan_reset_o,
  output logic [NUM_CHAN-1:0] timeout_o,
  output logic                seq_busy_o,
  output logic                seq_done_o
);

  localparam int unsigned     IDX_W   = $clog2(NUM_CHAN + 1);
  localparam int unsigned     RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  // Retry hold ends one cycle early so the RELEASE cycle completes exactly HOLD_CYCLES of reset.
  localparam logic [CNT_WIDTH-1:0] RETRY_LAST = CNT_WIDTH'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST   = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]     IDX_END    = IDX_W'(NUM_CHAN);
  localparam logic [RTY_W-1:0]     RTY_MAX    = RTY_W'(MAX_RETRY);

  // Elaboration-time parameter sanity
  if (NUM_CHAN < 1 || NUM_CHAN > 16) begin : g_bad_num_chan
    $error("fofb_reset_sequencer: NUM_CHAN must be 1..16");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
    $error("fofb_reset_sequencer: CNT_WIDTH must be 1..32");
  end
  if (64'(HOLD_CYCLES) > CNT_MAX) begin : g_bad_hold
    $error("fofb_reset_sequencer: HOLD_CYCLES does not fit CNT_WIDTH");
  end
  if (64'(STAGGER_CYCLES) > CNT_MAX) begin : g_bad_stagger
    $error("fofb_reset_sequencer: STAGGER_CYCLES does not fit CNT_WIDTH");
  end
  if (64'(TIMEOUT_CYCLES) > CNT_MAX) begin : g_bad_timeout
    $error("fofb_reset_sequencer: TIMEOUT_CYCLES does not fit CNT_WIDTH");
  end

  typedef enum logic [2:0] {
    S_HOLD, S_SCAN, S_RELEASE, S_WAIT, S_RETRY, S_GAP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RTY_W-1:0]     retry_q, retry_d;
  logic [NUM_CHAN-1:0]  chan_rst_d, timeout_d, idx_oh;
  logic                 busy_d, done_d, en_bit, done_bit;

  assign idx_oh   = NUM_CHAN'(1) << idx_q;
  assign en_bit   = |(chan_en_i & idx_oh);
  assign done_bit = |(done_i & idx_oh);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef RSTSEQ_RELINK_EN
  logic [NUM_CHAN-1:0] passed_q, passed_d, pending_q, pending_d, done_prev_q;
  logic [NUM_CHAN-1:0] fall_now, service, pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                relink_q, relink_d;

  assign fall_now = done_prev_q & ~done_i & passed_q & chan_en_i;
  assign service  = pending_q | fall_now;
  assign pick_oh  = NUM_CHAN'(1) << pick_idx;

  // Lowest-index dropped channel is serviced first
  always_comb begin
    pick_idx = '0;
    for (int k = int'(NUM_CHAN) - 1; k >= 0; k--) begin
      if (service[k]) pick_idx = IDX_W'(k);
    end
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    idx_d      = idx_q;
    retry_d    = retry_q;
    chan_rst_d = chan_reset_o;
    timeout_d  = timeout_o;
`ifdef RSTSEQ_RELINK_EN
    passed_d   = passed_q;
    pending_d  = relink_q ? (pending_q | fall_now) : pending_q;
    relink_d   = relink_q;
`endif

    case (state_q)
      S_HOLD: begin
        chan_rst_d = '1;
        if (cnt_q >= HOLD_LAST) begin
          state_d = S_SCAN;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        if (idx_q == IDX_END) begin
          state_d = S_DONE;
        end else if (!en_bit) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          retry_d = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        chan_rst_d = chan_reset_o & ~idx_oh;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (done_bit) begin
          cnt_d = '0;
`ifdef RSTSEQ_RELINK_EN
          passed_d = passed_q | idx_oh;
          if (relink_q) begin
            relink_d = 1'b0;
            state_d  = S_DONE;
          end else
`endif
          if (STAGGER_CYCLES == 0) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SCAN;
          end else begin
            state_d = S_GAP;
          end
        end else if (cnt_q >= TMO_LAST) begin
          chan_rst_d = chan_reset_o | idx_oh;
          cnt_d      = '0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_RETRY;
          end else begin
            timeout_d = timeout_o | idx_oh;
`ifdef RSTSEQ_RELINK_EN
            if (relink_q) begin
              relink_d = 1'b0;
              state_d  = S_DONE;
            end else
`endif
            begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_SCAN;
            end
          end
        end
      end
      S_RETRY: begin
        if (cnt_q >= RETRY_LAST) state_d = S_RELEASE;
      end
      S_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        if (start_i) begin
          chan_rst_d = '1;
          timeout_d  = '0;
          idx_d      = '0;
          cnt_d      = '0;
          retry_d    = '0;
          state_d    = S_HOLD;
`ifdef RSTSEQ_RELINK_EN
          passed_d   = '0;
          pending_d  = '0;
        end else if (|service) begin
          idx_d      = pick_idx;
          chan_rst_d = chan_reset_o | pick_oh;
          cnt_d      = '0;
          retry_d    = '0;
          pending_d  = service & ~pick_oh;
          passed_d   = passed_q & ~pick_oh;
          relink_d   = 1'b1;
          state_d    = S_RETRY;
`endif
        end
      end
      default: state_d = S_HOLD;
    endcase

    busy_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      retry_q      <= '0;
      chan_reset_o <= '1;
      timeout_o    <= '0;
      seq_busy_o   <= 1'b1;
      seq_done_o   <= 1'b0;
`ifdef RSTSEQ_RELINK_EN
      passed_q     <= '0;
      pending_q    <= '0;
      done_prev_q  <= '0;
      relink_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      chan_reset_o <= chan_rst_d;
      timeout_o    <= timeout_d;
      seq_busy_o   <= busy_d;
      seq_done_o   <= done_d;
`ifdef RSTSEQ_RELINK_EN
      passed_q     <= passed_d;
      pending_q    <= pending_d;
      done_prev_q  <= done_i;
      relink_q     <= relink_d;
`endif
    end
  end

endmodule
